// File: rtl/lane_align_sel_if.sv
// Lane-alignment bus: candidate lanes in, selected lane and lock status out.
// The master side drives the lanes; the slave side is the aligner.
interface lane_align_sel_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        valid_in;
  logic [NUM_CH*DATA_W-1:0] datain;
  logic                     realign;
  logic                     valid;
  logic [DATA_W-1:0]        dataout;
  logic                     locked;
  logic [CH_W-1:0]          lock_ch;
  logic                     align_err;

  modport master (
    output valid_in, datain, realign,
    input  valid, dataout, locked, lock_ch, align_err
  );

  modport slave (
    input  valid_in, datain, realign,
    output valid, dataout, locked, lock_ch, align_err
  );
endinterface

// File: rtl/lane_align_sel.sv
// Lane aligner: counts sync words per shifted lane, locks onto the first lane to
// reach LOCK_LEVEL and forwards it. Define LANE_ALIGN_LOSS_DETECT_EN for loss-of-sync detection.
module lane_align_sel #(
  parameter int                NUM_CH       = 16,
  parameter int                DATA_W       = 16,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = 16'b1000_0001_0111_1110,
  parameter int                LOCK_LEVEL   = 16,
  parameter int                SYNC_PERIOD  = 64,
  parameter int                MISS_LEVEL   = 4
) (
  input logic             clk,
  input logic             rst,
  lane_align_sel_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(LOCK_LEVEL + 1);
  localparam logic [CNT_W-1:0] LOCK_CNT  = CNT_W'(LOCK_LEVEL);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_LEVEL - 1);

  if (NUM_CH < 2 || NUM_CH > 32 || DATA_W < 1 || LOCK_LEVEL < 1 || LOCK_LEVEL > 255 ||
      SYNC_PERIOD < 2 || SYNC_PERIOD > 1024 || MISS_LEVEL < 1 || MISS_LEVEL > 15) begin : g_bad_params
    $error("lane_align_sel: parameter out of legal range");
  end

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  sync_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  sync_cnt_d [NUM_CH];
  logic              valid_q;
  logic [DATA_W-1:0] dataout_q;
  logic              locked_q;
  logic [CH_W-1:0]   lock_ch_q;
  logic              align_err_q;

  logic [DATA_W-1:0] lane_word_s [NUM_CH];
  logic [NUM_CH-1:0] match_s;
  logic [NUM_CH-1:0] win_s;
  logic              win_any_s;
  logic [CH_W-1:0]   win_idx_s;
  logic              sel_valid_s;
  logic [DATA_W-1:0] sel_word_s;

  // Per-lane sync detection, saturating count and "this match completes the lock" flag.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lane_word_s[i] = bus.datain[i*DATA_W +: DATA_W];
      match_s[i]     = bus.valid_in[i] && (lane_word_s[i] == SYNC_PATTERN);
      win_s[i]       = match_s[i] && (sync_cnt_q[i] == LOCK_LAST);
      if (match_s[i] && (sync_cnt_q[i] != LOCK_CNT)) begin
        sync_cnt_d[i] = sync_cnt_q[i] + CNT_W'(1);
      end else begin
        sync_cnt_d[i] = sync_cnt_q[i];
      end
    end
  end

  // Lowest-index winner among lanes completing lock this cycle.
  always_comb begin
    win_any_s = 1'b0;
    win_idx_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_s[i] && !win_any_s) begin
        win_any_s = 1'b1;
        win_idx_s = CH_W'(i);
      end else begin
        win_any_s = win_any_s;
      end
    end
  end

  assign sel_valid_s = bus.valid_in[lock_ch_q];
  assign sel_word_s  = lane_word_s[lock_ch_q];

`ifdef LANE_ALIGN_LOSS_DETECT_EN
  localparam int WC_W = $clog2(SYNC_PERIOD);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(SYNC_PERIOD - 1);

  logic [WC_W-1:0] word_cnt_q;
  logic [3:0]      miss_cnt_q;
  logic            at_sync_pos_s;
  logic            miss_hit_s;
  logic            lose_s;

  // Expected sync slot is the last word of each frame counted from the winning sync.
  always_comb begin
    at_sync_pos_s = sel_valid_s && (word_cnt_q == WC_LAST);
    miss_hit_s    = at_sync_pos_s && (sel_word_s != SYNC_PATTERN);
    lose_s        = miss_hit_s && ((miss_cnt_q + 4'd1) == 4'(MISS_LEVEL));
  end
`endif

  // Search/lock FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      valid_q     <= 1'b0;
      dataout_q   <= '0;
      locked_q    <= 1'b0;
      lock_ch_q   <= '0;
      align_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) sync_cnt_q[i] <= '0;
`ifdef LANE_ALIGN_LOSS_DETECT_EN
      word_cnt_q  <= '0;
      miss_cnt_q  <= 4'd0;
`endif
    end else if (bus.realign) begin
      state_q     <= SEARCH;
      valid_q     <= 1'b0;
      dataout_q   <= '0;
      locked_q    <= 1'b0;
      lock_ch_q   <= '0;
      align_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) sync_cnt_q[i] <= '0;
`ifdef LANE_ALIGN_LOSS_DETECT_EN
      word_cnt_q  <= '0;
      miss_cnt_q  <= 4'd0;
`endif
    end else begin
      align_err_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          valid_q   <= 1'b0;
          dataout_q <= '0;
          if (win_any_s) begin
            state_q   <= LOCKED;
            locked_q  <= 1'b1;
            lock_ch_q <= win_idx_s;
            for (int i = 0; i < NUM_CH; i++) sync_cnt_q[i] <= '0;
`ifdef LANE_ALIGN_LOSS_DETECT_EN
            word_cnt_q <= '0;
            miss_cnt_q <= 4'd0;
`endif
          end else begin
            locked_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) sync_cnt_q[i] <= sync_cnt_d[i];
          end
        end
        LOCKED: begin
          for (int i = 0; i < NUM_CH; i++) sync_cnt_q[i] <= '0;
`ifdef LANE_ALIGN_LOSS_DETECT_EN
          if (lose_s) begin
            state_q     <= SEARCH;
            locked_q    <= 1'b0;
            valid_q     <= 1'b0;
            dataout_q   <= '0;
            lock_ch_q   <= '0;
            align_err_q <= 1'b1;
            word_cnt_q  <= '0;
            miss_cnt_q  <= 4'd0;
          end else begin
            locked_q <= 1'b1;
            valid_q  <= sel_valid_s;
            if (sel_valid_s) begin
              dataout_q  <= sel_word_s;
              word_cnt_q <= (word_cnt_q == WC_LAST) ? '0 : word_cnt_q + WC_W'(1);
              if (at_sync_pos_s) begin
                miss_cnt_q <= miss_hit_s ? miss_cnt_q + 4'd1 : 4'd0;
              end
            end
          end
`else
          locked_q <= 1'b1;
          valid_q  <= sel_valid_s;
          if (sel_valid_s) begin
            dataout_q <= sel_word_s;
          end
`endif
        end
        default: begin
          state_q   <= SEARCH;
          valid_q   <= 1'b0;
          dataout_q <= '0;
          locked_q  <= 1'b0;
          lock_ch_q <= '0;
        end
      endcase
    end
  end

  assign bus.valid     = valid_q;
  assign bus.dataout   = dataout_q;
  assign bus.locked    = locked_q;
  assign bus.lock_ch   = lock_ch_q;
  assign bus.align_err = align_err_q;
endmodule

// File: tb/tb_lane_align_sel.sv
// Self-checking bench for lane_align_sel (default build; loss-detect scenario
// is included when LANE_ALIGN_LOSS_DETECT_EN is defined).
module tb_lane_align_sel;
  localparam int NUM_CH = 16;
  localparam int DATA_W = 16;
  localparam logic [15:0] SYNC = 16'h817E;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  lane_align_sel_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus_if ();

  lane_align_sel #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus_if.valid_in = '0;
    bus_if.datain   = '0;
    bus_if.realign  = 1'b0;
  endtask

  task automatic put(input int lane, input logic [15:0] w);
    bus_if.datain[lane*DATA_W +: DATA_W] = w;
    bus_if.valid_in[lane] = 1'b1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic send_syncs(input int lane, input int n);
    for (int k = 0; k < n; k++) begin
      clear_in();
      put(lane, SYNC);
      step();
    end
    clear_in();
  endtask

  task automatic test_reset();
    clear_in();
    put(2, SYNC);
    bus_if.realign = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_in();
    total_cnt++; if (bus_if.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus_if.valid); else pass_cnt++;
    total_cnt++; if (bus_if.dataout !== 16'h0000) $display("FAIL reset_dataout: got %h want 0000", bus_if.dataout); else pass_cnt++;
    total_cnt++; if (bus_if.locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", bus_if.locked); else pass_cnt++;
    total_cnt++; if (bus_if.lock_ch !== 4'd0) $display("FAIL reset_lock_ch: got %0d want 0", bus_if.lock_ch); else pass_cnt++;
    total_cnt++; if (bus_if.align_err !== 1'b0) $display("FAIL reset_align_err: got %b want 0", bus_if.align_err); else pass_cnt++;
  endtask

  task automatic test_lock_single();
    logic [15:0] e;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      clear_in();
      put(5, SYNC);
      bus_if.datain[6*DATA_W +: DATA_W] = SYNC;   // lane 6 carries sync but is not valid
      step();
      if (k == 7) begin
        clear_in();
        put(5, 16'h1111);
        step();
      end
      if (k == 14) begin
        total_cnt++; if (bus_if.locked !== 1'b0) $display("FAIL lock_early: got %b want 0", bus_if.locked); else pass_cnt++;
      end
    end
    total_cnt++; if (bus_if.locked !== 1'b1) $display("FAIL lock_locked: got %b want 1", bus_if.locked); else pass_cnt++;
    total_cnt++; if (bus_if.lock_ch !== 4'd5) $display("FAIL lock_ch5: got %0d want 5", bus_if.lock_ch); else pass_cnt++;
    total_cnt++; if (bus_if.valid !== 1'b0) $display("FAIL lock_sync_hidden: got valid %b want 0", bus_if.valid); else pass_cnt++;
    clear_in();
    put(5, 16'hA5A5);
    exp_q.push_back(16'hA5A5);
    step();
    clear_in();
    e = exp_q.pop_front();
    total_cnt++; if (bus_if.valid !== 1'b1) $display("FAIL lock_first_valid: got %b want 1", bus_if.valid); else pass_cnt++;
    total_cnt++; if (bus_if.dataout !== e) $display("FAIL lock_first_data: got %h want %h", bus_if.dataout, e); else pass_cnt++;
  endtask

  task automatic test_tie();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      clear_in();
      put(3, SYNC);
      put(9, SYNC);
      step();
    end
    clear_in();
    total_cnt++; if (bus_if.locked !== 1'b1) $display("FAIL tie_locked: got %b want 1", bus_if.locked); else pass_cnt++;
    total_cnt++; if (bus_if.lock_ch !== 4'd3) $display("FAIL tie_lowest: got %0d want 3", bus_if.lock_ch); else pass_cnt++;
    do_reset();
    send_syncs(9, 1);
    for (int k = 0; k < 15; k++) begin
      clear_in();
      put(3, SYNC);
      put(9, SYNC);
      step();
    end
    clear_in();
    total_cnt++; if (bus_if.lock_ch !== 4'd9) $display("FAIL first_to_level: got %0d want 9", bus_if.lock_ch); else pass_cnt++;
  endtask

  task automatic test_passthrough();
    logic [15:0] e;
    logic [15:0] last_w;
    logic        v;
    do_reset();
    send_syncs(5, 16);
    last_w = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      clear_in();
      for (int j = 0; j < NUM_CH; j++) begin
        if (j != 5) begin
          bus_if.valid_in[j] = 1'($urandom_range(0, 1));
          bus_if.datain[j*DATA_W +: DATA_W] = 16'($urandom);
        end
      end
      v = ((k % 2) == 0);
      if (v) begin
        put(5, ((k % 4) == 0) ? 16'h1234 : 16'h5678);
        exp_q.push_back(((k % 4) == 0) ? 16'h1234 : 16'h5678);
      end else begin
        bus_if.datain[5*DATA_W +: DATA_W] = 16'hDEAD;
      end
      step();
      total_cnt++; if (bus_if.valid !== v) $display("FAIL pass_valid[%0d]: got %b want %b", k, bus_if.valid, v); else pass_cnt++;
      if (v) begin
        e = exp_q.pop_front();
        last_w = e;
        total_cnt++; if (bus_if.dataout !== e) $display("FAIL pass_data[%0d]: got %h want %h", k, bus_if.dataout, e); else pass_cnt++;
      end else begin
        total_cnt++; if (bus_if.dataout !== last_w) $display("FAIL pass_hold[%0d]: got %h want %h", k, bus_if.dataout, last_w); else pass_cnt++;
      end
    end
    clear_in();
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL pass_queue_drained: got %0d want 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_realign();
    do_reset();
    send_syncs(5, 15);
    put(5, SYNC);
    bus_if.realign = 1'b1;
    step();
    clear_in();
    total_cnt++; if (bus_if.locked !== 1'b0) $display("FAIL realign_beats_lock: got %b want 0", bus_if.locked); else pass_cnt++;
    total_cnt++; if (bus_if.align_err !== 1'b0) $display("FAIL realign_no_err: got %b want 0", bus_if.align_err); else pass_cnt++;
    send_syncs(5, 15);
    total_cnt++; if (bus_if.locked !== 1'b0) $display("FAIL realign_cleared: got %b want 0", bus_if.locked); else pass_cnt++;
    send_syncs(5, 1);
    total_cnt++; if (bus_if.locked !== 1'b1) $display("FAIL realign_relock: got %b want 1", bus_if.locked); else pass_cnt++;
    put(5, 16'h4242);
    bus_if.realign = 1'b1;
    step();
    clear_in();
    total_cnt++; if ({bus_if.valid, bus_if.locked, bus_if.dataout} !== 18'd0) $display("FAIL realign_locked_drop: got v%b l%b d%h want 0", bus_if.valid, bus_if.locked, bus_if.dataout); else pass_cnt++;
    send_syncs(5, 10);
    bus_if.realign = 1'b1;
    step();
    clear_in();
    send_syncs(5, 15);
    total_cnt++; if (bus_if.locked !== 1'b0) $display("FAIL realign_search_clear: got %b want 0", bus_if.locked); else pass_cnt++;
  endtask

  task automatic test_rst_mid_lock();
    do_reset();
    send_syncs(5, 16);
    put(5, 16'h7777);
    step();
    total_cnt++; if (bus_if.dataout !== 16'h7777) $display("FAIL rst_pre_data: got %h want 7777", bus_if.dataout); else pass_cnt++;
    clear_in();
    put(5, 16'h8888);
    bus_if.realign = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_in();
    total_cnt++; if ({bus_if.valid, bus_if.dataout, bus_if.locked, bus_if.lock_ch, bus_if.align_err} !== 23'd0) $display("FAIL rst_mid_outputs: got v%b d%h l%b c%0d e%b want all 0", bus_if.valid, bus_if.dataout, bus_if.locked, bus_if.lock_ch, bus_if.align_err); else pass_cnt++;
    send_syncs(5, 15);
    total_cnt++; if (bus_if.locked !== 1'b0) $display("FAIL rst_relock_early: got %b want 0", bus_if.locked); else pass_cnt++;
    send_syncs(5, 1);
    total_cnt++; if (bus_if.lock_ch !== 4'd5 || bus_if.locked !== 1'b1) $display("FAIL rst_relock: got l%b c%0d want l1 c5", bus_if.locked, bus_if.lock_ch); else pass_cnt++;
  endtask

`ifdef LANE_ALIGN_LOSS_DETECT_EN
  task automatic send_frame(input logic [15:0] sync_word);
    for (int p = 1; p < 64; p++) begin
      clear_in();
      put(5, (p == 10) ? SYNC : 16'h0100 + 16'(p));
      step();
    end
    clear_in();
    put(5, sync_word);
    step();
    clear_in();
  endtask

  task automatic test_loss();
    do_reset();
    send_syncs(5, 16);
    for (int f = 0; f < 3; f++) begin
      send_frame(16'hBAD0 + 16'(f));
      total_cnt++; if (bus_if.locked !== 1'b1) $display("FAIL loss_hold[%0d]: got %b want 1", f, bus_if.locked); else pass_cnt++;
      total_cnt++; if (bus_if.dataout !== 16'hBAD0 + 16'(f)) $display("FAIL loss_passthru[%0d]: got %h want %h", f, bus_if.dataout, 16'hBAD0 + 16'(f)); else pass_cnt++;
    end
    send_frame(SYNC);
    total_cnt++; if (bus_if.locked !== 1'b1) $display("FAIL loss_good_sync: got %b want 1", bus_if.locked); else pass_cnt++;
    for (int f = 0; f < 4; f++) begin
      send_frame(16'hBEE0 + 16'(f));
      if (f < 3) begin
        total_cnt++; if (bus_if.align_err !== 1'b0) $display("FAIL loss_no_err[%0d]: got %b want 0", f, bus_if.align_err); else pass_cnt++;
      end
    end
    total_cnt++; if ({bus_if.align_err, bus_if.locked, bus_if.valid} !== 3'b100) $display("FAIL loss_drop: got e%b l%b v%b want e1 l0 v0", bus_if.align_err, bus_if.locked, bus_if.valid); else pass_cnt++;
    put(5, 16'h0001);
    step();
    clear_in();
    total_cnt++; if (bus_if.align_err !== 1'b0) $display("FAIL loss_err_pulse: got %b want 0", bus_if.align_err); else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_lock_single();
    test_tie();
    test_passthrough();
    test_realign();
    test_rst_mid_lock();
`ifdef LANE_ALIGN_LOSS_DETECT_EN
    test_loss();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/lane_align_sel.md
LANE_ALIGN_SEL -- requirements
Module: lane_align_sel

Interface
REQ-001 Parameter NUM_CH, default 16; number of candidate shifted lanes, legal range 2..32.
REQ-002 Parameter DATA_W, default 16; word width per lane.
REQ-003 Parameter SYNC_PATTERN, default 16'b1000_0001_0111_1110; sync word, DATA_W bits wide.
REQ-004 Parameter LOCK_LEVEL, default 16; sync matches a lane needs to win lock, legal range 1..255.
REQ-005 Parameter SYNC_PERIOD, default 64; valid words per frame on the locked lane, sync word included, legal range 2..1024.
REQ-006 Parameter MISS_LEVEL, default 4; consecutive missed syncs that drop lock, legal range 1..15.
REQ-007 Port clk, input, 1 bit; single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1 bit; reset is synchronous and active-high.
REQ-009 Port valid_in, input, NUM_CH bits; per-lane word-valid strobe.
REQ-010 Port datain, input, NUM_CH*DATA_W bits; lane i word occupies bits [i*DATA_W +: DATA_W].
REQ-011 Port realign, input, 1 bit; single-cycle request to drop lock and restart the search.
REQ-012 Port valid, output, 1 bit; dataout is valid.
REQ-013 Port dataout, output, DATA_W bits; word from the selected lane.
REQ-014 Port locked, output, 1 bit; high while the state is LOCKED.
REQ-015 Port lock_ch, output, $clog2(NUM_CH) bits; index of the selected lane.
REQ-016 Port align_err, output, 1 bit; one-cycle pulse when lock is lost.

Function
REQ-017 The block SHALL implement a two-state FSM with states SEARCH and LOCKED; the state after reset is SEARCH.
REQ-018 In SEARCH, sync_cnt[i] SHALL increment when valid_in[i]=1 and the lane i word equals SYNC_PATTERN; other words SHALL leave sync_cnt[i] unchanged.
REQ-019 sync_cnt[i] SHALL saturate at LOCK_LEVEL and SHALL never wrap.
REQ-020 In SEARCH, a lane whose match would raise its count to LOCK_LEVEL SHALL win; on the next cycle the state SHALL be LOCKED, lock_ch SHALL hold the winner and every sync_cnt SHALL be 0.
REQ-021 Simultaneous winners SHALL resolve to the lowest lane index.
REQ-022 In LOCKED, sync_cnt SHALL stay 0 and SHALL NOT count; lock_ch SHALL stay frozen.
REQ-023 Output latency SHALL be exactly 1 cycle: in LOCKED, valid(n+1)=valid_in[lock_ch](n) and dataout(n+1)=lane lock_ch word(n).
REQ-024 The first output cycle SHALL carry the word that follows the winning sync word; the winning sync word itself SHALL NOT be output.
REQ-025 Outside LOCKED, valid SHALL be 0 and dataout SHALL be 0.
REQ-026 dataout SHALL update only on cycles with valid_in[lock_ch]=1; it SHALL hold its value otherwise.
REQ-027 A realign pulse SHALL, on the next cycle, set the state to SEARCH, clear all counters and drive valid to 0 and locked to 0.
REQ-028 realign SHALL take priority over a lock event or a loss event in the same cycle; align_err SHALL NOT pulse in that case.
REQ-029 A realign asserted while already in SEARCH SHALL clear all sync_cnt.

Reset
REQ-030 When rst=1 at a clock edge, the state SHALL be SEARCH and all counters SHALL be 0.
REQ-031 When rst=1 at a clock edge, valid, dataout, locked, lock_ch and align_err SHALL all be 0.
REQ-032 rst SHALL override realign and all other inputs.
REQ-033 rst asserted while LOCKED SHALL drop the lock on the next cycle.

Configuration
REQ-034 Macro LANE_ALIGN_LOSS_DETECT_EN defined: in LOCKED, word_cnt SHALL be loaded with 0 on the winning sync word.
REQ-035 With LANE_ALIGN_LOSS_DETECT_EN: word_cnt SHALL increment on each valid_in[lock_ch]=1 and wrap from SYNC_PERIOD-1 to 0.
REQ-036 With LANE_ALIGN_LOSS_DETECT_EN: the word at word_cnt=SYNC_PERIOD-1 is the expected sync; a mismatch SHALL increment miss_cnt and a match SHALL clear it.
REQ-037 With LANE_ALIGN_LOSS_DETECT_EN: sync words at any other position SHALL be ignored.
REQ-038 With LANE_ALIGN_LOSS_DETECT_EN: when miss_cnt reaches MISS_LEVEL, on the next cycle the state SHALL be SEARCH and align_err SHALL be 1 for one cycle; expected-position words SHALL still pass through to dataout.
REQ-039 Macro undefined: LOCKED SHALL persist until rst or realign, align_err SHALL be tied to 0, and no word_cnt or miss_cnt logic SHALL exist.

Verification
REQ-040 NUM_CH=16, LOCK_LEVEL=16, SYNC_PATTERN on lane 5 only, valid every cycle, 16 syncs -> locked=1, lock_ch=5 one cycle after the 16th sync; next word appears on dataout one cycle later.
REQ-041 Lanes 3 and 9 reach their 16th sync in the same cycle -> lock_ch=3.
REQ-042 Locked on lane 5, valid_in[5] toggling 1/0, data 16'h1234 then 16'h5678 -> dataout follows with 1-cycle latency and valid tracks valid_in[5]; other lanes have no effect.
REQ-043 Loss detect enabled, MISS_LEVEL=4, SYNC_PERIOD=64, sync corrupted in 4 consecutive frames -> align_err pulses once, locked=0 and valid=0 the cycle after the 4th miss; a corruption on 3 frames then a good sync -> lock retained.
REQ-044 realign and the 16th sync in the same cycle -> stays SEARCH, all counts 0, no lock.
REQ-045 rst pulsed mid-LOCKED -> all outputs 0 on the next cycle; relock requires a full 16 fresh syncs.
